// File: rtl/buffer_readout.sv
// rtl/buffer_readout.sv - reads nwords buffer words from address 0 and streams them out as bytes, MSB first
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, nwords     readout request and word count (sampled in IDLE only)
//   abort             cancels a readout in progress
//   rd, raddr, rdata  buffer read port (rdata combinational from raddr while rd=1)
//   tx_data, tx_valid, tx_ready  byte stream to the downstream link
//   busy, done        readout in progress / one-cycle normal-completion pulse
module buffer_readout #(
  parameter int DATBITS = 24,
  parameter int ADDBITS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDBITS:0]   nwords,
  input  logic               abort,
  output logic               rd,
  output logic [ADDBITS-1:0] raddr,
  input  logic [DATBITS-1:0] rdata,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic               done
);

  localparam int NB  = DATBITS / 8;
  localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BCW-1:0]     LAST_BYTE = BCW'(NB - 1);
  localparam logic [BCW-1:0]     BC_ONE    = BCW'(1);
  localparam logic [ADDBITS:0]   W_ONE     = (ADDBITS + 1)'(1);
  localparam logic [ADDBITS-1:0] A_ONE     = ADDBITS'(1);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, FINISH} state_t;

  state_t               state_q, state_d;
  logic [ADDBITS:0]     nwords_q, nwords_d;
  logic [ADDBITS:0]     widx_q, widx_d;
  logic [ADDBITS-1:0]   raddr_q, raddr_d;
  logic [DATBITS-1:0]   shreg_q, shreg_d;
  logic [BCW-1:0]       bcnt_q, bcnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      nwords_q <= '0;
      widx_q   <= '0;
      raddr_q  <= '0;
      shreg_q  <= '0;
      bcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      nwords_q <= nwords_d;
      widx_q   <= widx_d;
      raddr_q  <= raddr_d;
      shreg_q  <= shreg_d;
      bcnt_q   <= bcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    nwords_d = nwords_q;
    widx_d   = widx_q;
    raddr_d  = raddr_q;
    shreg_d  = shreg_q;
    bcnt_d   = bcnt_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (nwords != '0) begin
            nwords_d = nwords;
            widx_d   = '0;
            raddr_d  = '0;
            state_d  = FETCH;
          end else begin
            state_d  = FINISH;
          end
        end
      end
      FETCH: begin
        shreg_d = rdata;
        bcnt_d  = '0;
        state_d = SEND;
      end
      SEND: begin
        if (tx_ready) begin
          // The outgoing byte always sits in the top 8 bits; shifting exposes the next one.
          shreg_d = shreg_q << 8;
          bcnt_d  = bcnt_q + BC_ONE;
          if (bcnt_q == LAST_BYTE) begin
            if (widx_q == nwords_q - W_ONE) begin
              state_d = FINISH;
            end else begin
              widx_d  = widx_q + W_ONE;
              raddr_d = raddr_q + A_ONE;
              state_d = FETCH;
            end
          end
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort overrides any transfer or advance decided above; raddr keeps its last value.
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      shreg_d = '0;
      bcnt_d  = '0;
    end
  end

  assign rd       = (state_q == FETCH);
  assign raddr    = raddr_q;
  assign tx_valid = (state_q == SEND);
  assign tx_data  = shreg_q[DATBITS-1 -: 8];
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FINISH);

endmodule
